// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - ID decode plus EX/MEM/WB control pipeline with branch flush and load-use stall.
// Decodes the ID opcode, carries control through EX/MEM/WB, resolves BT in EX and inserts load-use bubbles.
module control_pipe #(
  parameter int REG_ADDR_W       = 4,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [3:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_ra,
  input  logic [REG_ADDR_W-1:0] id_rb,
  input  logic                  ex_cmp_result,
  output logic                  id_re_a,
  output logic                  id_re_b,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  ex_valid,
  output logic [1:0]            ex_sel_b,
  output logic [3:0]            ex_alu_ctrl,
  output logic                  ex_cmp_en,
  output logic                  ex_branch,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  wb_valid,
  output logic                  wb_reg_we,
  output logic                  wb_sel_data_out,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam int CNT_W = (LOAD_USE_BUBBLES > 1) ? 2 : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_USE_BUBBLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [3:0] OP_BT  = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            sel_b;
    logic [3:0]            alu_ctrl;
    logic                  cmp_en;
    logic                  branch;
    logic                  mem_we;
    logic                  mem_re;
    logic                  reg_we;
    logic                  sel_data;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic                  mem_we;
    logic                  mem_re;
    logic                  reg_we;
    logic                  sel_data;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_we;
    logic                  sel_data;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  typedef enum logic {S_IDLE, S_STALL} state_t;

  ex_ctrl_t   dec, ex_d, ex_q;
  mem_ctrl_t  mem_d, mem_q;
  wb_ctrl_t   wb_d, wb_q;
  state_t     state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic       flag_d, flag_q;
  logic       re_a, re_b, hazard, taken, insert_bubble;

  always_comb begin
    dec  = '0;
    re_a = 1'b0;
    re_b = 1'b0;
    if (id_valid) begin
      dec.valid    = 1'b1;
      dec.alu_ctrl = id_opcode;
      dec.rd       = id_rd;
      dec.cmp_en   = (id_opcode == OP_CMP);
      dec.branch   = (id_opcode == OP_BT);
      dec.mem_we   = (id_opcode == OP_ST);
      dec.mem_re   = (id_opcode == OP_LD);
      dec.sel_data = (id_opcode == OP_LD);
      dec.sel_b    = (id_opcode == OP_LD) ? 2'b01 : (id_opcode == OP_ST) ? 2'b10 : 2'b00;
      dec.reg_we   = !((id_opcode == OP_CMP) || (id_opcode == OP_ST) ||
                       (id_opcode == OP_BT)  || (id_opcode == OP_NOP));
      re_a = !((id_opcode == OP_MOV) || (id_opcode == OP_BT) || (id_opcode == OP_NOP));
      re_b = !((id_opcode == OP_NOT) || (id_opcode == OP_MOV) || (id_opcode == OP_LD) ||
               (id_opcode == OP_BT)  || (id_opcode == OP_NOP));
    end
  end

  // LD is the only opcode with mem_re, so it doubles as the "EX is a load" test.
  assign taken  = ex_q.valid & ex_q.branch & flag_q;
  assign hazard = (state_q == S_IDLE) & id_valid & ex_q.valid & ex_q.mem_re &
                  ((re_a & (id_ra == ex_q.rd)) | (re_b & (id_rb == ex_q.rd)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    insert_bubble = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (taken) begin
          insert_bubble = 1'b1;
        end else if (hazard) begin
          state_d       = S_STALL;
          cnt_d         = CNT_LOAD;
          insert_bubble = 1'b1;
        end
      end
      S_STALL: begin
        if (taken) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          insert_bubble = 1'b1;
        end else if (cnt_q == CNT_ONE) begin
          // last stall cycle: the held ID instruction moves into EX at this edge
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d         = cnt_q - CNT_ONE;
          insert_bubble = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ex_d           = insert_bubble ? '0 : dec;
    mem_d.valid    = ex_q.valid;
    mem_d.mem_we   = ex_q.mem_we;
    mem_d.mem_re   = ex_q.mem_re;
    mem_d.reg_we   = ex_q.reg_we;
    mem_d.sel_data = ex_q.sel_data;
    mem_d.rd       = ex_q.rd;
    wb_d.valid     = mem_q.valid;
    wb_d.reg_we    = mem_q.reg_we;
    wb_d.sel_data  = mem_q.sel_data;
    wb_d.rd        = mem_q.rd;
    flag_d         = (ex_q.valid & ex_q.cmp_en) ? ex_cmp_result : flag_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign id_re_a         = re_a;
  assign id_re_b         = re_b;
  assign flush_o         = taken;
  assign stall_o         = ~taken & (hazard | (state_q == S_STALL));
  assign ex_valid        = ex_q.valid;
  assign ex_sel_b        = ex_q.sel_b;
  assign ex_alu_ctrl     = ex_q.alu_ctrl;
  assign ex_cmp_en       = ex_q.cmp_en;
  assign ex_branch       = ex_q.branch;
  assign mem_valid       = mem_q.valid;
  assign mem_we          = mem_q.mem_we;
  assign mem_re          = mem_q.mem_re;
  assign wb_valid        = wb_q.valid;
  assign wb_reg_we       = wb_q.reg_we;
  assign wb_sel_data_out = wb_q.sel_data;
  assign wb_rd           = wb_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - bench for control_pipe with one and three load-use bubbles side by side.
// Upstream fetch advances its program when the instruction is taken into EX or killed by a flush.
module tb_control_pipe;

  localparam logic [3:0] CMP = 4'b1000, NOTO = 4'b0110, MOV = 4'b1011, LD = 4'b1100;
  localparam logic [3:0] ST = 4'b1101, BT = 4'b1110, NOP = 4'b1111;

  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       cmp;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid[2];
  logic [3:0] id_opcode[2], id_rd[2], id_ra[2], id_rb[2];
  logic       ex_cmp_result[2];
  logic       id_re_a[2], id_re_b[2], stall_a[2], flush_a[2], ex_valid[2];
  logic [1:0] ex_sel_b[2];
  logic [3:0] ex_alu_ctrl[2];
  logic       ex_cmp_en[2], ex_branch[2], mem_valid[2], mem_we[2], mem_re[2];
  logic       wb_valid[2], wb_reg_we[2], wb_sel[2];
  logic [3:0] wb_rd[2];

  control_pipe #(.REG_ADDR_W(4), .LOAD_USE_BUBBLES(1)) dut1 (
    .clk(clk), .reset(rst), .id_valid(id_valid[0]), .id_opcode(id_opcode[0]),
    .id_rd(id_rd[0]), .id_ra(id_ra[0]), .id_rb(id_rb[0]), .ex_cmp_result(ex_cmp_result[0]),
    .id_re_a(id_re_a[0]), .id_re_b(id_re_b[0]), .stall_o(stall_a[0]), .flush_o(flush_a[0]),
    .ex_valid(ex_valid[0]), .ex_sel_b(ex_sel_b[0]), .ex_alu_ctrl(ex_alu_ctrl[0]),
    .ex_cmp_en(ex_cmp_en[0]), .ex_branch(ex_branch[0]), .mem_valid(mem_valid[0]),
    .mem_we(mem_we[0]), .mem_re(mem_re[0]), .wb_valid(wb_valid[0]), .wb_reg_we(wb_reg_we[0]),
    .wb_sel_data_out(wb_sel[0]), .wb_rd(wb_rd[0]));

  control_pipe #(.REG_ADDR_W(4), .LOAD_USE_BUBBLES(3)) dut3 (
    .clk(clk), .reset(rst), .id_valid(id_valid[1]), .id_opcode(id_opcode[1]),
    .id_rd(id_rd[1]), .id_ra(id_ra[1]), .id_rb(id_rb[1]), .ex_cmp_result(ex_cmp_result[1]),
    .id_re_a(id_re_a[1]), .id_re_b(id_re_b[1]), .stall_o(stall_a[1]), .flush_o(flush_a[1]),
    .ex_valid(ex_valid[1]), .ex_sel_b(ex_sel_b[1]), .ex_alu_ctrl(ex_alu_ctrl[1]),
    .ex_cmp_en(ex_cmp_en[1]), .ex_branch(ex_branch[1]), .mem_valid(mem_valid[1]),
    .mem_we(mem_we[1]), .mem_re(mem_re[1]), .wb_valid(wb_valid[1]), .wb_reg_we(wb_reg_we[1]),
    .wb_sel_data_out(wb_sel[1]), .wb_rd(wb_rd[1]));

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   nb[2] = '{1, 3};
  ins_t prog[2][$];
  int   pc[2];
  ins_t m_ex[2], m_mem[2], m_wb[2];
  logic m_flag[2];
  int   stall_until[2];
  int   cyc = 0, scyc = 0;
  int   n_stall[2], n_flush[2], n_wbld[2], first_wbld[2];
  int   op_cnt[2][16], first_ex[2][16];

  function automatic logic reads_a(logic [3:0] op);
    return !(op == MOV || op == BT || op == NOP);
  endfunction

  function automatic logic reads_b(logic [3:0] op);
    return !(op == NOTO || op == MOV || op == LD || op == BT || op == NOP);
  endfunction

  function automatic logic writes_reg(logic [3:0] op);
    return !(op == CMP || op == ST || op == BT || op == NOP);
  endfunction

  task automatic chk(string nm, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", nm, nb[k], cyc, act, exp);
    end
  endtask

  task automatic clear_model(int k);
    m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
    m_flag[k] = 1'b0;
    stall_until[k] = -1;
  endtask

  task automatic clear_stats();
    scyc = 0;
    for (int k = 0; k < 2; k++) begin
      n_stall[k] = 0; n_flush[k] = 0; n_wbld[k] = 0; first_wbld[k] = -1;
      for (int o = 0; o < 16; o++) begin
        op_cnt[k][o] = 0; first_ex[k][o] = -1;
      end
    end
  endtask

  task automatic step();
    ins_t cur[2];
    logic tk[2], hz[2], adv;
    for (int k = 0; k < 2; k++) begin
      cur[k] = (!rst && pc[k] < prog[k].size()) ? prog[k][pc[k]] : '0;
      if (rst) clear_model(k);
      id_valid[k] = cur[k].v; id_opcode[k] = cur[k].op;
      id_rd[k] = cur[k].rd; id_ra[k] = cur[k].ra; id_rb[k] = cur[k].rb;
      ex_cmp_result[k] = m_ex[k].cmp;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tk[k] = m_ex[k].v && m_ex[k].op == BT && m_flag[k];
      hz[k] = cur[k].v && m_ex[k].v && m_ex[k].op == LD && cyc > stall_until[k] &&
              ((reads_a(cur[k].op) && cur[k].ra == m_ex[k].rd) ||
               (reads_b(cur[k].op) && cur[k].rb == m_ex[k].rd));
      chk("stall_o", k, stall_a[k], !tk[k] && (hz[k] || cyc <= stall_until[k]));
      chk("flush_o", k, flush_a[k], tk[k]);
      chk("id_re_a", k, id_re_a[k], cur[k].v && reads_a(cur[k].op));
      chk("id_re_b", k, id_re_b[k], cur[k].v && reads_b(cur[k].op));
      chk("ex_valid", k, ex_valid[k], m_ex[k].v);
      chk("ex_sel_b", k, ex_sel_b[k], !m_ex[k].v ? 0 : m_ex[k].op == LD ? 1 : m_ex[k].op == ST ? 2 : 0);
      chk("ex_alu_ctrl", k, ex_alu_ctrl[k], m_ex[k].v ? m_ex[k].op : 0);
      chk("ex_cmp_en", k, ex_cmp_en[k], m_ex[k].v && m_ex[k].op == CMP);
      chk("ex_branch", k, ex_branch[k], m_ex[k].v && m_ex[k].op == BT);
      chk("mem_valid", k, mem_valid[k], m_mem[k].v);
      chk("mem_we", k, mem_we[k], m_mem[k].v && m_mem[k].op == ST);
      chk("mem_re", k, mem_re[k], m_mem[k].v && m_mem[k].op == LD);
      chk("wb_valid", k, wb_valid[k], m_wb[k].v);
      chk("wb_reg_we", k, wb_reg_we[k], m_wb[k].v && writes_reg(m_wb[k].op));
      chk("wb_sel_data_out", k, wb_sel[k], m_wb[k].v && m_wb[k].op == LD);
      chk("wb_rd", k, wb_rd[k], m_wb[k].v ? m_wb[k].rd : 0);
      if (stall_a[k]) n_stall[k]++;
      if (flush_a[k]) n_flush[k]++;
      if (ex_valid[k]) begin
        op_cnt[k][ex_alu_ctrl[k]]++;
        if (first_ex[k][ex_alu_ctrl[k]] < 0) first_ex[k][ex_alu_ctrl[k]] = scyc;
      end
      if (wb_valid[k] && wb_sel[k]) begin
        n_wbld[k]++;
        if (first_wbld[k] < 0) first_wbld[k] = scyc;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        clear_model(k);
      end else begin
        if (m_ex[k].v && m_ex[k].op == CMP) m_flag[k] = ex_cmp_result[k];
        m_wb[k] = m_mem[k];
        m_mem[k] = m_ex[k];
        adv = 1'b0;
        if (tk[k]) begin
          m_ex[k] = '0; stall_until[k] = -1; adv = 1'b1;
        end else if (hz[k]) begin
          m_ex[k] = '0; stall_until[k] = cyc + nb[k];
        end else if (cyc < stall_until[k]) begin
          m_ex[k] = '0;
        end else begin
          m_ex[k] = cur[k]; adv = 1'b1;
        end
        if (adv && pc[k] < prog[k].size()) pc[k]++;
      end
    end
    cyc++; scyc++;
    #1;
  endtask

  task automatic add(logic [3:0] op, logic [3:0] rd, logic [3:0] ra, logic [3:0] rb, logic cmp);
    ins_t t;
    t.v = 1'b1; t.op = op; t.rd = rd; t.ra = ra; t.rb = rb; t.cmp = cmp;
    prog[0].push_back(t);
    prog[1].push_back(t);
  endtask

  task automatic new_program();
    for (int k = 0; k < 2; k++) begin
      prog[k].delete();
      pc[k] = 0;
    end
    clear_stats();
  endtask

  task automatic begin_scn();
    rst = 1'b1;
    step();
    rst = 1'b0;
    new_program();
  endtask

  task automatic run_prog(int maxc);
    int n = 0;
    while ((pc[0] < prog[0].size() || pc[1] < prog[1].size()) && n < maxc) begin
      step();
      n++;
    end
    repeat (4) step();
    for (int k = 0; k < 2; k++) chk("program_drained", k, pc[k], prog[k].size());
  endtask

  initial begin
    int exp_stall[2] = '{2, 4};
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      id_valid[k] = 1'b0; id_opcode[k] = '0; id_rd[k] = '0; id_ra[k] = '0; id_rb[k] = '0;
      ex_cmp_result[k] = 1'b0;
      clear_model(k);
    end
    new_program();
    #1;
    step();
    step();

    begin_scn();
    for (int o = 0; o < 16; o++) add(4'(o), 4'(o), 4'd0, 4'd0, 1'b0);
    run_prog(200);
    for (int k = 0; k < 2; k++) begin
      for (int o = 0; o < 16; o++) chk("sweep_ex_once", k, op_cnt[k][o], 1);
      chk("sweep_no_flush", k, n_flush[k], 0);
    end

    begin_scn();
    add(LD, 4'd3, 4'd0, 4'd0, 1'b0);
    add(4'b0001, 4'd4, 4'd3, 4'd0, 1'b0);
    add(4'b0011, 4'd5, 4'd0, 4'd0, 1'b0);
    run_prog(200);
    for (int k = 0; k < 2; k++) begin
      chk("loaduse_stall_cycles", k, n_stall[k], exp_stall[k]);
      chk("loaduse_add_after_ld", k, first_ex[k][1] - first_ex[k][12], exp_stall[k]);
      chk("loaduse_add_once", k, op_cnt[k][1], 1);
      chk("loaduse_tail_intact", k, first_ex[k][3] - first_ex[k][1], 1);
    end

    begin_scn();
    add(LD, 4'd3, 4'd0, 4'd0, 1'b0);
    add(MOV, 4'd6, 4'd3, 4'd3, 1'b0);
    run_prog(200);
    for (int k = 0; k < 2; k++) begin
      chk("mov_no_stall", k, n_stall[k], 0);
      chk("mov_after_ld", k, first_ex[k][11] - first_ex[k][12], 1);
    end

    begin_scn();
    add(CMP, 4'd0, 4'd1, 4'd2, 1'b1);
    add(BT, 4'd0, 4'd0, 4'd0, 1'b0);
    add(4'b0010, 4'd7, 4'd0, 4'd0, 1'b0);
    add(4'b0011, 4'd8, 4'd0, 4'd0, 1'b0);
    run_prog(200);
    for (int k = 0; k < 2; k++) begin
      chk("taken_flush_count", k, n_flush[k], 1);
      chk("taken_killed", k, op_cnt[k][2], 0);
      chk("taken_one_bubble", k, first_ex[k][3] - first_ex[k][14], 2);
    end

    begin_scn();
    add(CMP, 4'd0, 4'd1, 4'd2, 1'b0);
    add(BT, 4'd0, 4'd0, 4'd0, 1'b0);
    add(4'b0010, 4'd7, 4'd0, 4'd0, 1'b0);
    add(4'b0011, 4'd8, 4'd0, 4'd0, 1'b0);
    run_prog(200);
    for (int k = 0; k < 2; k++) begin
      chk("nottaken_flush_count", k, n_flush[k], 0);
      chk("nottaken_kept", k, op_cnt[k][2], 1);
      chk("nottaken_no_bubble", k, first_ex[k][2] - first_ex[k][14], 1);
    end

    begin_scn();
    add(CMP, 4'd0, 4'd1, 4'd2, 1'b1);
    add(LD, 4'd5, 4'd0, 4'd0, 1'b0);
    add(BT, 4'd0, 4'd0, 4'd0, 1'b0);
    add(4'b0001, 4'd6, 4'd5, 4'd5, 1'b0);
    add(4'b0011, 4'd8, 4'd0, 4'd0, 1'b0);
    run_prog(200);
    for (int k = 0; k < 2; k++) begin
      chk("simul_flush_count", k, n_flush[k], 1);
      chk("simul_no_stall", k, n_stall[k], 0);
      chk("simul_killed", k, op_cnt[k][1], 0);
      chk("simul_one_bubble", k, first_ex[k][3] - first_ex[k][14], 2);
    end

    begin_scn();
    add(LD, 4'd3, 4'd0, 4'd0, 1'b0);
    add(4'b0001, 4'd4, 4'd3, 4'd0, 1'b0);
    add(4'b0010, 4'd5, 4'd0, 4'd0, 1'b0);
    add(4'b0011, 4'd6, 4'd0, 4'd0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    new_program();
    add(LD, 4'd7, 4'd0, 4'd0, 1'b0);
    add(4'b0010, 4'd9, 4'd0, 4'd0, 1'b0);
    run_prog(200);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ld_in_ex", k, first_ex[k][12], 1);
      chk("rst_ld_wb_count", k, n_wbld[k], 1);
      chk("rst_ld_wb_cycle", k, first_wbld[k], 3);
      chk("rst_no_stale_add", k, op_cnt[k][1], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog dut1 cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
